seg_capture: RTL

//  Inverse of the team's hex-to-7-segment decoding. Snoops a multiplexed 7-seg bus
//  (one pattern per strobe, digit select), debounces each digit and maps stable

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_capture_if.sv | 20 ++
 rtl/seg_digit_filter.sv | 70 +++++++
 rtl/seg_capture.sv | 121 ++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment constants, FSM state type and pattern-to-nibble decode.
// Used by seg_capture and any display self-check logic.
package seg_pkg;

  typedef enum logic {
    CAPTURE = 1'b0,
    HOLD    = 1'b1
  } fsm_t;

  localparam logic [6:0] SEG_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Returns {valid, nibble}; valid=0 for any pattern outside the table.
  function automatic logic [4:0] seg2nib(input logic [6:0] pat);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_CODE[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_capture_if.sv
// Snooped 7-seg bus plus reconstructed-byte valid/ready stream.
// master = bus driver / consumer side, slave = seg_capture.
interface seg_capture_if;
  logic [6:0] seg_in;
  logic       digit_sel;
  logic       seg_strobe;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output seg_in, digit_sel, seg_strobe, data_ready,
    input  data_out, data_valid
  );

  modport slave (
    input  seg_in, digit_sel, seg_strobe, data_ready,
    output data_out, data_valid
  );
endinterface

// File: rtl/seg_digit_filter.sv
// Per-digit debounce: tracks last pattern and run length, decodes once the
// run first reaches STABLE_CNT.
module seg_digit_filter
  import seg_pkg::*;
#(
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       strobe,
  input  logic       clr_ok,
  output logic [3:0] nib,
  output logic       ok,
  output logic       err
);

  localparam logic [3:0] CNT = 4'(STABLE_CNT);

  logic [6:0] r_last;
  logic [3:0] r_cnt;
  logic [3:0] r_nib;
  logic       r_ok;
  logic       r_err;

  logic       w_same;
  logic [3:0] w_cnt_nxt;
  logic       w_hit;
  logic [4:0] w_dec;

  assign w_same    = (seg_in == r_last);
  assign w_cnt_nxt = !w_same ? 4'd1 :
                     (r_cnt == CNT) ? r_cnt : r_cnt + 4'd1;
  // Only the strobe that brings the run up to CNT decodes
  assign w_hit     = strobe && (w_cnt_nxt == CNT) &&
                     (!w_same || (r_cnt != CNT));
  assign w_dec     = seg2nib(seg_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= '0;
      r_cnt  <= '0;
      r_nib  <= '0;
      r_ok   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (strobe) begin
        r_last <= seg_in;
        r_cnt  <= w_cnt_nxt;
        if (!w_same) r_ok <= 1'b0;
        if (w_hit) begin
          if (w_dec[4]) begin
            r_nib <= w_dec[3:0];
            r_ok  <= 1'b1;
          end else begin
            r_ok  <= 1'b0;
            r_err <= 1'b1;
          end
        end
      end
      if (clr_ok) r_ok <= 1'b0;
    end
  end

  assign nib = r_nib;
  assign ok  = r_ok;
  assign err = r_err;

endmodule

// File: rtl/seg_capture.sv
// Reconstructs a byte from a multiplexed 7-seg bus; optional saturating
// error counter enabled by defining SEG_CAPTURE_ERRCNT_EN.
module seg_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CNT     = 3,
  parameter int EMIT_ON_CHANGE = 1
) (
  input  logic       clk,
  input  logic       reset,
  seg_capture_if.slave bus,
  output logic       pat_err
`ifdef SEG_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  fsm_t       r_state;
  fsm_t       w_state_nxt;
  logic [7:0] r_data;
  logic       r_valid;
  logic [7:0] r_last_emit;
  logic       r_emit_vld;

  logic [3:0] w_nib [2];
  logic [1:0] w_ok;
  logic [1:0] w_err;
  logic [1:0] w_stb;
  logic [7:0] w_byte;
  logic       w_both;
  logic       w_new;
  logic       w_load;
  logic       w_ack;
  logic       w_clr_ok;

  assign w_stb[0] = bus.seg_strobe & ~bus.digit_sel;
  assign w_stb[1] = bus.seg_strobe &  bus.digit_sel;

  for (genvar d = 0; d < 2; d++) begin : g_dig
    seg_digit_filter #(.STABLE_CNT(STABLE_CNT)) u_flt (
      .clk    (clk),
      .reset  (reset),
      .seg_in (bus.seg_in),
      .strobe (w_stb[d]),
      .clr_ok (w_clr_ok),
      .nib    (w_nib[d]),
      .ok     (w_ok[d]),
      .err    (w_err[d])
    );
  end

  assign w_byte = {w_nib[0], w_nib[1]};
  assign w_both = &w_ok;
  // r_emit_vld=0 forces the first byte after reset out, even 0x00
  assign w_new  = (EMIT_ON_CHANGE == 0) || !r_emit_vld ||
                  (w_byte != r_last_emit);

  always_ff @(posedge clk) begin
    if (reset) r_state <= CAPTURE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      CAPTURE: if (w_both && w_new) w_state_nxt = HOLD;
      HOLD:    if (bus.data_ready)  w_state_nxt = CAPTURE;
      default: w_state_nxt = CAPTURE;
    endcase
  end

  always_comb begin
    w_load   = 1'b0;
    w_ack    = 1'b0;
    w_clr_ok = 1'b0;
    unique case (r_state)
      CAPTURE: begin
        w_load   = w_both && w_new;
        w_clr_ok = w_both && !w_new;
      end
      HOLD: begin
        w_ack    = bus.data_ready;
        w_clr_ok = bus.data_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last_emit <= '0;
      r_emit_vld  <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_byte;
      r_valid <= 1'b1;
    end else if (w_ack) begin
      r_valid     <= 1'b0;
      r_last_emit <= r_data;
      r_emit_vld  <= 1'b1;
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign pat_err        = |w_err;

`ifdef SEG_CAPTURE_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset)                             r_err_cnt <= '0;
    else if (pat_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_count = r_err_cnt;
`endif

endmodule
